dmem_responder: RTL



---
 rtl/dmem_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder over a word-addressed data RAM.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, then is presented in RESP until consumed.
module dmem_responder #(
  parameter int DBITS     = 32,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [DBITS-1:0]   req_addr,
  input  logic [DBITS-1:0]   req_wdata,
  input  logic [DBITS/8-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DBITS-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  output logic [DBITS-1:0]   served_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic r_live, r_we;
  logic [3:0] r_cnt;
  logic [DBITS-1:0] r_addr, r_wdata;
  logic [DBITS/8-1:0] r_be;
  logic [DBITS-1:0] r_mem [2**ADDR_BITS] = '{default: '0};
  logic w_accept, w_enter, w_done, w_err;
  logic [ADDR_BITS-1:0] w_idx;
  assign w_accept = req_valid && req_ready;
  assign w_enter  = r_state == WAIT && r_cnt == 4'd0;
  assign w_done   = r_state == RESP && rsp_ready;
  assign w_err    = r_addr[1:0] != 2'b0 || (r_addr >> (ADDR_BITS + 2)) != '0;
  assign w_idx    = r_addr[ADDR_BITS+1:2];
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_accept ? WAIT : IDLE) :
             r_state == WAIT ? (w_enter ? RESP : WAIT) :
             (w_done ? IDLE : RESP);
  // req_ready stays low through reset and rises on the first clock edge after it
  always_comb begin
    req_ready = r_live && r_state == IDLE;
    rsp_valid = r_state == RESP;
    busy      = r_state != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_live       <= 1'b0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      served_count <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_enter) begin
        rsp_err   <= w_err;
        rsp_rdata <= (w_err || r_we) ? '0 : r_mem[w_idx];
      end
      if (w_done) served_count <= served_count + 1'b1;
    end
  // RAM is deliberately outside the reset domain; the store lands on the edge entering RESP
  always_ff @(posedge clk)
    if (w_enter && r_we && !w_err)
      for (int i = 0; i < DBITS/8; i++)
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
endmodule
